bus_cycle_sequencer: RTL and testbench

//  Sequences one external 8085 machine cycle (M1 fetch, mem/IO read, mem/IO write, INTA) through T-states.

---
 rtl/i8085_pkg.sv | 42 ++++
 rtl/bus_status_enc.sv | 29 ++
 rtl/bus_cycle_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_bus_cycle_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/i8085_pkg.sv
// rtl/i8085_pkg.sv - shared 8085 bus cycle types, status codes and T-state encodings
// Purpose: types and constants shared by the bus cycle sequencer and the decoder.
// Ports: none (package).
package i8085_pkg;

  // Machine cycle kinds requested by the decoder; codes 6 and 7 are illegal.
  typedef enum logic [2:0] {
    CYC_FETCH  = 3'd0,
    CYC_MEM_RD = 3'd1,
    CYC_MEM_WR = 3'd2,
    CYC_IO_RD  = 3'd3,
    CYC_IO_WR  = 3'd4,
    CYC_INTA   = 3'd5
  } cyc_t;

  // Bus status as {IOMn, S1, S0}.
  typedef logic [2:0] status_t;

  localparam status_t STATUS_HALT   = 3'b000;
  localparam status_t STATUS_FETCH  = 3'b011;
  localparam status_t STATUS_MEM_RD = 3'b010;
  localparam status_t STATUS_MEM_WR = 3'b001;
  localparam status_t STATUS_IO_RD  = 3'b110;
  localparam status_t STATUS_IO_WR  = 3'b101;
  localparam status_t STATUS_INTA   = 3'b111;

  // One-hot T-state vector {T1,T2,T3,T4,T5,T6,Treset}; all zero in TWAIT/THOLD.
  localparam logic [6:0] TS_T1     = 7'b1000000;
  localparam logic [6:0] TS_T2     = 7'b0100000;
  localparam logic [6:0] TS_T3     = 7'b0010000;
  localparam logic [6:0] TS_T4     = 7'b0001000;
  localparam logic [6:0] TS_T5     = 7'b0000100;
  localparam logic [6:0] TS_T6     = 7'b0000010;
  localparam logic [6:0] TS_TRESET = 7'b0000001;
  localparam logic [6:0] TS_NONE   = 7'b0000000;

  // Writes strobe WRn; every other cycle kind strobes RDn and captures AD.
  function automatic logic cyc_is_write(cyc_t t);
    return (t == CYC_MEM_WR) || (t == CYC_IO_WR);
  endfunction

endpackage

// File: rtl/bus_status_enc.sv
// rtl/bus_status_enc.sv - maps a requested cycle kind to its {IOMn,S1,S0} status code
// Purpose: combinational status encoder; also flags whether the cycle code is legal.
// Ports:
//   cyc_type  in  3  requested cycle kind (cyc_t encoding)
//   status    out 3  {IOMn,S1,S0} for that kind, halt code when illegal
//   legal     out 1  cyc_type is one of the six defined cycle kinds
module bus_status_enc
  import i8085_pkg::*;
(
  input  logic [2:0] cyc_type,
  output status_t    status,
  output logic       legal
);

  always_comb begin
    status = STATUS_HALT;
    legal  = 1'b1;
    case (cyc_type)
      CYC_FETCH:  status = STATUS_FETCH;
      CYC_MEM_RD: status = STATUS_MEM_RD;
      CYC_MEM_WR: status = STATUS_MEM_WR;
      CYC_IO_RD:  status = STATUS_IO_RD;
      CYC_IO_WR:  status = STATUS_IO_WR;
      CYC_INTA:   status = STATUS_INTA;
      default:    legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/bus_cycle_sequencer.sv
// rtl/bus_cycle_sequencer.sv - 8085 machine cycle sequencer with READY wait states and HOLD arbitration
// Purpose: walks one external machine cycle through T-states and drives the multiplexed AD bus.
// Ports:
//   phi1, reset            clock and synchronous active-high reset
//   cyc_req, cyc_type      cycle request and kind (sampled in TRESET or a cycle's last T-state)
//   cyc_lng                FETCH only: 1 selects the 6-T-state M1
//   addr, wdata            cycle address and write data, latched on entry to T1
//   ad_in, ready, hold     AD bus input, external READY, external bus request
//   ad_out, a_hi, ad_oe    AD bus drive, address high byte, AD output enable
//   ALE, RDn, WRn          address latch enable and active-low strobes
//   IOMn, S1, S0           cycle status
//   rdata, rdata_vld       captured read data and its one-cycle valid pulse
//   cyc_done               high during the last T-state of a cycle
//   t_state, t_wait, hlda  one-hot T-state, TWAIT flag, hold acknowledge
module bus_cycle_sequencer
  import i8085_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              phi1,
  input  logic              reset,
  input  logic              cyc_req,
  input  logic [2:0]        cyc_type,
  input  logic              cyc_lng,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] ad_in,
  input  logic              ready,
  input  logic              hold,
  output logic [DATA_W-1:0] ad_out,
  output logic [ADDR_W-9:0] a_hi,
  output logic              ad_oe,
  output logic              ALE,
  output logic              RDn,
  output logic              WRn,
  output logic              IOMn,
  output logic              S1,
  output logic              S0,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_vld,
  output logic              cyc_done,
  output logic [6:0]        t_state,
  output logic              t_wait,
  output logic              hlda
);

  typedef enum logic [3:0] {
    S_TRESET, S_T1, S_T2, S_TWAIT, S_T3, S_T4, S_T5, S_T6, S_THOLD
  } state_t;

  state_t              state, nxt;
  cyc_t                lat_type;
  logic                lat_lng;
  logic [DATA_W-1:0]   lat_wdata;
  status_t             status_q;
  status_t             req_status;
  logic                req_legal;
  logic                start;
  logic                in_last;
  logic                lat_write;

  bus_status_enc u_status_enc (
    .cyc_type (cyc_type),
    .status   (req_status),
    .legal    (req_legal)
  );

  assign start     = cyc_req && req_legal;
  assign lat_write = cyc_is_write(lat_type);
  assign in_last   = ((state == S_T3) && (lat_type != CYC_FETCH)) ||
                     ((state == S_T4) && !lat_lng) ||
                     (state == S_T6);
  assign {IOMn, S1, S0} = status_q;

  // hold wins over a new request, and is only looked at between cycles.
  always_comb begin
    nxt = state;
    if (in_last || state == S_TRESET) begin
      if (hold)       nxt = S_THOLD;
      else if (start) nxt = S_T1;
      else            nxt = S_TRESET;
    end else begin
      case (state)
        S_T1:            nxt = S_T2;
        S_T2, S_TWAIT:   nxt = ready ? S_T3 : S_TWAIT;
        S_T3:            nxt = S_T4;
        S_T4:            nxt = S_T5;
        S_T5:            nxt = S_T6;
        S_THOLD:         nxt = hold ? S_THOLD : S_TRESET;
        default:         nxt = S_TRESET;
      endcase
    end
  end

  // Outputs are registered against the next state so they line up with it.
  always_ff @(posedge phi1) begin
    if (reset) begin
      state     <= S_TRESET;
      lat_type  <= CYC_FETCH;
      lat_lng   <= 1'b0;
      lat_wdata <= '0;
      status_q  <= STATUS_HALT;
      ad_out    <= '0;
      a_hi      <= '0;
      ad_oe     <= 1'b0;
      ALE       <= 1'b0;
      RDn       <= 1'b1;
      WRn       <= 1'b1;
      rdata     <= '0;
      rdata_vld <= 1'b0;
      cyc_done  <= 1'b0;
      t_state   <= TS_TRESET;
      t_wait    <= 1'b0;
      hlda      <= 1'b0;
    end else begin
      state     <= nxt;
      t_wait    <= (nxt == S_TWAIT);
      hlda      <= (nxt == S_THOLD);
      // Latched type/lng are stable by the time T3/T4/T6 can be entered.
      cyc_done  <= ((nxt == S_T3) && (lat_type != CYC_FETCH)) ||
                   ((nxt == S_T4) && !lat_lng) ||
                   (nxt == S_T6);

      rdata_vld <= 1'b0;
      if (state == S_T3 && !lat_write) begin
        rdata     <= ad_in;
        rdata_vld <= 1'b1;
      end

      case (nxt)
        S_T1:     t_state <= TS_T1;
        S_T2:     t_state <= TS_T2;
        S_T3:     t_state <= TS_T3;
        S_T4:     t_state <= TS_T4;
        S_T5:     t_state <= TS_T5;
        S_T6:     t_state <= TS_T6;
        S_TRESET: t_state <= TS_TRESET;
        default:  t_state <= TS_NONE;
      endcase

      case (nxt)
        S_T1: begin
          lat_type  <= cyc_t'(cyc_type);
          lat_lng   <= cyc_lng;
          lat_wdata <= wdata;
          status_q  <= req_status;
          ALE       <= 1'b1;
          ad_oe     <= 1'b1;
          ad_out    <= addr[7:0];
          a_hi      <= addr[ADDR_W-1:8];
          RDn       <= 1'b1;
          WRn       <= 1'b1;
        end
        S_T2: begin
          ALE <= 1'b0;
          if (lat_write) begin
            WRn    <= 1'b0;
            ad_out <= lat_wdata;
            ad_oe  <= 1'b1;
          end else begin
            RDn   <= 1'b0;
            ad_oe <= 1'b0;
          end
        end
        S_TWAIT, S_T3: begin
          // strobes and bus held
        end
        S_THOLD: begin
          ALE      <= 1'b0;
          ad_oe    <= 1'b0;
          RDn      <= 1'b1;
          WRn      <= 1'b1;
          status_q <= STATUS_HALT;
        end
        default: begin
          // T4..T6 and TRESET: strobes released, bus not driven
          ALE   <= 1'b0;
          ad_oe <= 1'b0;
          RDn   <= 1'b1;
          WRn   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// tb/tb_bus_cycle_sequencer.sv - directed self-checking bench for bus_cycle_sequencer
module tb_bus_cycle_sequencer;

  logic        phi1 = 1'b0;
  logic        reset, cyc_req, cyc_lng, ready, hold;
  logic [2:0]  cyc_type;
  logic [15:0] addr;
  logic [7:0]  wdata, ad_in;
  logic [7:0]  ad_out, a_hi, rdata;
  logic        ad_oe, ALE, RDn, WRn, IOMn, S1, S0, rdata_vld, cyc_done, t_wait, hlda;
  logic [6:0]  t_state;

  int checks = 0;
  int errors = 0;

  always #5 phi1 = ~phi1;

  bus_cycle_sequencer #(.ADDR_W(16), .DATA_W(8)) dut (
    .phi1(phi1), .reset(reset), .cyc_req(cyc_req), .cyc_type(cyc_type), .cyc_lng(cyc_lng),
    .addr(addr), .wdata(wdata), .ad_in(ad_in), .ready(ready), .hold(hold),
    .ad_out(ad_out), .a_hi(a_hi), .ad_oe(ad_oe), .ALE(ALE), .RDn(RDn), .WRn(WRn),
    .IOMn(IOMn), .S1(S1), .S0(S0), .rdata(rdata), .rdata_vld(rdata_vld),
    .cyc_done(cyc_done), .t_state(t_state), .t_wait(t_wait), .hlda(hlda)
  );

  task automatic tick();
    @(posedge phi1);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // t_state, ALE, RDn, WRn and status in one call
  task automatic chk_ctl(input string tag, input logic [6:0] ts, input logic ale,
                         input logic rdn, input logic wrn, input logic [2:0] st);
    checks++;
    assert (t_state === ts) else begin
      errors++; $error("FAIL %s t_state: observed %b expected %b", tag, t_state, ts);
    end
    checks++;
    assert ({ALE, RDn, WRn} === {ale, rdn, wrn}) else begin
      errors++; $error("FAIL %s ALE/RDn/WRn: observed %b expected %b", tag, {ALE, RDn, WRn}, {ale, rdn, wrn});
    end
    checks++;
    assert ({IOMn, S1, S0} === st) else begin
      errors++; $error("FAIL %s status: observed %b expected %b", tag, {IOMn, S1, S0}, st);
    end
  endtask

  initial begin
    reset = 1'b1; cyc_req = 1'b0; cyc_type = 3'd0; cyc_lng = 1'b0;
    addr = 16'h0000; wdata = 8'h00; ad_in = 8'h00; ready = 1'b1; hold = 1'b0;
    tick(); tick();

    // reset state
    chk_ctl("rst", 7'b0000001, 1'b0, 1'b1, 1'b1, 3'b000);
    chk1("rst ad_oe", ad_oe, 1'b0);
    chk1("rst hlda", hlda, 1'b0);
    chk1("rst cyc_done", cyc_done, 1'b0);
    chk1("rst rdata_vld", rdata_vld, 1'b0);
    chk8("rst rdata", rdata, 8'h00);
    chk8("rst ad_out", ad_out, 8'h00);
    chk8("rst a_hi", a_hi, 8'h00);
    reset = 1'b0;
    tick();
    chk_ctl("idle", 7'b0000001, 1'b0, 1'b1, 1'b1, 3'b000);

    // 1: MEM_RD
    cyc_req = 1'b1; cyc_type = 3'd1; addr = 16'h2050; ad_in = 8'hA5;
    tick();
    chk_ctl("rd T1", 7'b1000000, 1'b1, 1'b1, 1'b1, 3'b010);
    chk1("rd T1 ad_oe", ad_oe, 1'b1);
    chk8("rd T1 ad_out", ad_out, 8'h50);
    chk8("rd T1 a_hi", a_hi, 8'h20);
    cyc_req = 1'b0;
    tick();
    chk_ctl("rd T2", 7'b0100000, 1'b0, 1'b0, 1'b1, 3'b010);
    chk1("rd T2 ad_oe", ad_oe, 1'b0);
    tick();
    chk_ctl("rd T3", 7'b0010000, 1'b0, 1'b0, 1'b1, 3'b010);
    chk1("rd T3 cyc_done", cyc_done, 1'b1);
    chk8("rd T3 a_hi", a_hi, 8'h20);
    tick();
    chk_ctl("rd end", 7'b0000001, 1'b0, 1'b1, 1'b1, 3'b010);
    chk8("rd rdata", rdata, 8'hA5);
    chk1("rd rdata_vld", rdata_vld, 1'b1);
    chk1("rd end cyc_done", cyc_done, 1'b0);
    tick();
    chk1("rd vld pulse", rdata_vld, 1'b0);

    // 2: FETCH short then long
    cyc_req = 1'b1; cyc_type = 3'd0; cyc_lng = 1'b0; addr = 16'h1234;
    tick();
    chk_ctl("f4 T1", 7'b1000000, 1'b1, 1'b1, 1'b1, 3'b011);
    cyc_req = 1'b0;
    tick(); chk_ctl("f4 T2", 7'b0100000, 1'b0, 1'b0, 1'b1, 3'b011);
    tick(); chk_ctl("f4 T3", 7'b0010000, 1'b0, 1'b0, 1'b1, 3'b011);
    chk1("f4 T3 cyc_done", cyc_done, 1'b0);
    tick(); chk_ctl("f4 T4", 7'b0001000, 1'b0, 1'b1, 1'b1, 3'b011);
    chk1("f4 T4 cyc_done", cyc_done, 1'b1);
    chk1("f4 T4 ad_oe", ad_oe, 1'b0);
    tick(); chk_ctl("f4 end", 7'b0000001, 1'b0, 1'b1, 1'b1, 3'b011);
    cyc_req = 1'b1; cyc_lng = 1'b1;
    tick(); chk_ctl("f6 T1", 7'b1000000, 1'b1, 1'b1, 1'b1, 3'b011);
    cyc_req = 1'b0;
    tick(); chk_ctl("f6 T2", 7'b0100000, 1'b0, 1'b0, 1'b1, 3'b011);
    tick(); chk_ctl("f6 T3", 7'b0010000, 1'b0, 1'b0, 1'b1, 3'b011);
    tick(); chk_ctl("f6 T4", 7'b0001000, 1'b0, 1'b1, 1'b1, 3'b011);
    chk1("f6 T4 cyc_done", cyc_done, 1'b0);
    tick(); chk_ctl("f6 T5", 7'b0000100, 1'b0, 1'b1, 1'b1, 3'b011);
    chk1("f6 T5 cyc_done", cyc_done, 1'b0);
    tick(); chk_ctl("f6 T6", 7'b0000010, 1'b0, 1'b1, 1'b1, 3'b011);
    chk1("f6 T6 cyc_done", cyc_done, 1'b1);
    tick(); chk_ctl("f6 end", 7'b0000001, 1'b0, 1'b1, 1'b1, 3'b011);
    cyc_lng = 1'b0;

    // 3: MEM_WR with two wait states
    cyc_req = 1'b1; cyc_type = 3'd2; addr = 16'h4000; wdata = 8'h3C;
    tick(); chk_ctl("wr T1", 7'b1000000, 1'b1, 1'b1, 1'b1, 3'b001);
    cyc_req = 1'b0; ready = 1'b0;
    tick(); chk_ctl("wr T2", 7'b0100000, 1'b0, 1'b1, 1'b0, 3'b001);
    chk8("wr T2 ad_out", ad_out, 8'h3C);
    chk1("wr T2 ad_oe", ad_oe, 1'b1);
    chk1("wr T2 t_wait", t_wait, 1'b0);
    tick(); chk_ctl("wr W1", 7'b0000000, 1'b0, 1'b1, 1'b0, 3'b001);
    chk1("wr W1 t_wait", t_wait, 1'b1);
    chk8("wr W1 ad_out", ad_out, 8'h3C);
    tick(); chk_ctl("wr W2", 7'b0000000, 1'b0, 1'b1, 1'b0, 3'b001);
    chk1("wr W2 t_wait", t_wait, 1'b1);
    ready = 1'b1;
    tick(); chk_ctl("wr T3", 7'b0010000, 1'b0, 1'b1, 1'b0, 3'b001);
    chk1("wr T3 t_wait", t_wait, 1'b0);
    chk8("wr T3 ad_out", ad_out, 8'h3C);
    chk1("wr T3 cyc_done", cyc_done, 1'b1);
    tick(); chk_ctl("wr end", 7'b0000001, 1'b0, 1'b1, 1'b1, 3'b001);
    chk1("wr end rdata_vld", rdata_vld, 1'b0);

    // 4: hold raised mid IO_WR
    cyc_req = 1'b1; cyc_type = 3'd4; addr = 16'h0080; wdata = 8'h5A;
    tick(); chk_ctl("hw T1", 7'b1000000, 1'b1, 1'b1, 1'b1, 3'b101);
    cyc_req = 1'b0;
    tick(); chk_ctl("hw T2", 7'b0100000, 1'b0, 1'b1, 1'b0, 3'b101);
    hold = 1'b1;
    tick(); chk_ctl("hw T3", 7'b0010000, 1'b0, 1'b1, 1'b0, 3'b101);
    chk1("hw T3 hlda", hlda, 1'b0);
    tick(); chk_ctl("hw THOLD", 7'b0000000, 1'b0, 1'b1, 1'b1, 3'b000);
    chk1("hw THOLD hlda", hlda, 1'b1);
    chk1("hw THOLD ad_oe", ad_oe, 1'b0);
    tick(); chk1("hw THOLD2 hlda", hlda, 1'b1);
    hold = 1'b0;
    tick(); chk_ctl("hw TRESET", 7'b0000001, 1'b0, 1'b1, 1'b1, 3'b000);
    chk1("hw TRESET hlda", hlda, 1'b0);

    // 5: back-to-back MEM_RD then IO_RD
    cyc_req = 1'b1; cyc_type = 3'd1; addr = 16'h1111; ad_in = 8'h77;
    tick(); chk_ctl("bb1 T1", 7'b1000000, 1'b1, 1'b1, 1'b1, 3'b010);
    cyc_type = 3'd3; addr = 16'h3344;
    tick(); chk_ctl("bb1 T2", 7'b0100000, 1'b0, 1'b0, 1'b1, 3'b010);
    tick(); chk_ctl("bb1 T3", 7'b0010000, 1'b0, 1'b0, 1'b1, 3'b010);
    tick(); chk_ctl("bb2 T1", 7'b1000000, 1'b1, 1'b1, 1'b1, 3'b110);
    chk8("bb2 T1 ad_out", ad_out, 8'h44);
    chk8("bb2 T1 a_hi", a_hi, 8'h33);
    chk8("bb1 rdata", rdata, 8'h77);
    chk1("bb1 rdata_vld", rdata_vld, 1'b1);
    cyc_req = 1'b0; ad_in = 8'h88;
    tick(); chk_ctl("bb2 T2", 7'b0100000, 1'b0, 1'b0, 1'b1, 3'b110);
    tick(); chk_ctl("bb2 T3", 7'b0010000, 1'b0, 1'b0, 1'b1, 3'b110);
    tick(); chk_ctl("bb2 end", 7'b0000001, 1'b0, 1'b1, 1'b1, 3'b110);
    chk8("bb2 rdata", rdata, 8'h88);

    // 6: reset in TWAIT, then illegal cycle codes ignored
    cyc_req = 1'b1; cyc_type = 3'd1; addr = 16'h5566; ready = 1'b0;
    tick(); cyc_req = 1'b0;
    tick(); tick();
    chk1("rw TWAIT t_wait", t_wait, 1'b1);
    reset = 1'b1;
    tick(); chk_ctl("rw reset", 7'b0000001, 1'b0, 1'b1, 1'b1, 3'b000);
    chk1("rw reset t_wait", t_wait, 1'b0);
    reset = 1'b0; ready = 1'b1;
    cyc_req = 1'b1; cyc_type = 3'd7;
    tick(); chk_ctl("ill 7", 7'b0000001, 1'b0, 1'b1, 1'b1, 3'b000);
    cyc_type = 3'd6;
    tick(); chk_ctl("ill 6", 7'b0000001, 1'b0, 1'b1, 1'b1, 3'b000);
    chk1("ill ad_oe", ad_oe, 1'b0);
    cyc_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
